uart_cmd_ctrl: RTL and testbench
================================

Name: uart_cmd_ctrl

Overview:
- Command-frame sequencer between the UART byte receiver and the internal configuration bus.
- Collects 4-byte frames from the received byte stream: DEV, ADDR, DATA, TAIL. Wire order matches the bench serial model: 01 00 85 AA.
- Validates each frame, then issues one register write with a req/ack handshake.
- Reports completion and error status to the system controller.

Parameters:
- DEV_ID, 8'h01, device identifier this instance answers to.
- TAIL_BYTE, 8'hAA, required fourth (terminator) byte.
- ACK_TMO, 16'd1023, clk_sys cycles to wait for cfg_wr_ack before aborting.
- BYTE_TMO, 24'd200000, inter-byte idle limit in clk_sys cycles. Used only with UART_CMD_TMO_EN.

Ports:
- clk_sys  in  1  system clock; all logic on rising edge
- rst_n  in  1  asynchronous active-low reset
- rx_vld  in  1  one-cycle strobe: rx_data/rx_perr valid
- rx_data  in  8  received byte
- rx_perr  in  1  parity error on this byte (even parity, XOR of data bits)
- cfg_wr_req  out  1  write request, held until ack or timeout
- cfg_dev  out  8  captured DEV byte
- cfg_addr  out  8  captured ADDR byte
- cfg_wdata  out  8  captured DATA byte
- cfg_wr_ack  in  1  one-cycle write acknowledge
- busy  out  1  high in S_WR; rx bytes discarded
- frm_ok  out  1  one-cycle pulse: write acknowledged
- frm_err  out  1  one-cycle pulse: frame aborted
- err_code  out  2  cause, valid with frm_err, held until next frm_err

Behaviour:
- Reset values: all outputs 0; FSM in S_DEV; timers 0.
- States: S_DEV, S_ADDR, S_DATA, S_TAIL, S_WR.
- S_DEV, on rx_vld: capture rx_data into cfg_dev, go to S_ADDR.
- S_ADDR, on rx_vld: capture cfg_addr, go to S_DATA.
- S_DATA, on rx_vld: capture cfg_wdata, go to S_TAIL.
- S_TAIL, on rx_vld with rx_data==TAIL_BYTE:
  - if cfg_dev==DEV_ID: go to S_WR; cfg_wr_req rises on the next cycle.
  - else: silently return to S_DEV; no pulse, no write.
- S_TAIL, on rx_vld with rx_data!=TAIL_BYTE: frm_err, err_code=1, go to S_DEV. The wrong byte is not reused as DEV.
- rx_vld with rx_perr=1 in any receive state: frm_err, err_code=0, go to S_DEV, byte discarded.
- S_WR:
  - cfg_wr_req=1, busy=1; cfg_dev/addr/wdata stable.
  - Ack timer starts at 0 on entry, increments each cycle.
  - cfg_wr_ack=1: drop req next cycle, frm_ok pulse same cycle as the drop, go to S_DEV.
  - Timer reaches ACK_TMO without ack: drop req, frm_err with err_code=3, go to S_DEV.
  - Ack in the same cycle the timer reaches ACK_TMO: ack wins (frm_ok).
- rx_vld while in S_WR: byte ignored, no state effect.
- cfg_wr_ack outside S_WR: ignored.
- Latency: TAIL strobe to cfg_wr_req = 1 cycle; ack to frm_ok = 1 cycle.
- frm_ok and frm_err are never high together. Each pulse is exactly one cycle.
- Reset asserted mid-frame or mid-write: immediate return to reset values; cfg_wr_req drops asynchronously.
- Back-to-back frames with no idle gap between bytes are supported. A byte may arrive on the cycle after returning to S_DEV.

Optional Feature:
- UART_CMD_TMO_EN defined:
  - Idle counter runs in S_ADDR, S_DATA, S_TAIL; cleared on every rx_vld and in S_DEV/S_WR.
  - Counter reaching BYTE_TMO: frm_err with err_code=2, go to S_DEV; partial frame discarded.
  - rx_vld on the same cycle as expiry: the byte is accepted and no timeout occurs.
- Undefined: no idle counter; a partial frame waits indefinitely; err_code 2 never produced.

Test Plan:
- Bytes 01,00,85,AA (perr=0), ack 3 cycles after req -> one req with dev=01/addr=00/wdata=85, frm_ok once, frm_err never.
- 01,00,85,55 -> frm_err with err_code=1, no cfg_wr_req; following 01,10,22,AA -> write addr=10 wdata=22.
- 01,00 then 85 with rx_perr=1, then 01,00,85,AA -> frm_err code 0, then one clean write of 85.
- 02,00,85,AA -> no req, no pulse; then 01,00,85,AA -> normal write.
- Valid frame, ack withheld -> req high exactly ACK_TMO cycles, frm_err code 3. Repeat with ack on the timeout cycle -> frm_ok.
- With UART_CMD_TMO_EN, BYTE_TMO=100: 01,00 then 120 idle cycles -> frm_err code 2. Reset asserted during S_WR -> req low immediately, state S_DEV.

Source files
------------

// File: rtl/uart_cmd_ctrl.sv
// UART command-frame sequencer: collects DEV/ADDR/DATA/TAIL, validates, issues one cfg write via req/ack.
// Optional inter-byte idle timeout enabled by defining UART_CMD_TMO_EN (adds BYTE_TMO parameter).
module uart_cmd_ctrl #(
    parameter logic [7:0]  DEV_ID    = 8'h01,
    parameter logic [7:0]  TAIL_BYTE = 8'hAA,
    parameter logic [15:0] ACK_TMO   = 16'd1023
`ifdef UART_CMD_TMO_EN
    ,
    parameter logic [23:0] BYTE_TMO  = 24'd200000
`endif
) (
    input  logic       clk_sys,
    input  logic       rst_n,
    input  logic       rx_vld,
    input  logic [7:0] rx_data,
    input  logic       rx_perr,
    output logic       cfg_wr_req,
    output logic [7:0] cfg_dev,
    output logic [7:0] cfg_addr,
    output logic [7:0] cfg_wdata,
    input  logic       cfg_wr_ack,
    output logic       busy,
    output logic       frm_ok,
    output logic       frm_err,
    output logic [1:0] err_code
);

    typedef enum logic [2:0] {
        S_DEV  = 3'd0,
        S_ADDR = 3'd1,
        S_DATA = 3'd2,
        S_TAIL = 3'd3,
        S_WR   = 3'd4
    } state_t;

    localparam logic [1:0] ERR_PARITY = 2'd0;
    localparam logic [1:0] ERR_TAIL   = 2'd1;
    localparam logic [1:0] ERR_IDLE   = 2'd2;
    localparam logic [1:0] ERR_ACK    = 2'd3;

    state_t      state_q, state_d;
    logic [7:0]  dev_q, dev_d;
    logic [7:0]  addr_q, addr_d;
    logic [7:0]  wdata_q, wdata_d;
    logic        req_q, req_d;
    logic        ok_q, ok_d;
    logic        err_q, err_d;
    logic [1:0]  code_q, code_d;
    logic [15:0] ack_tmr_q, ack_tmr_d;
`ifdef UART_CMD_TMO_EN
    logic [23:0] idle_q, idle_d;
`endif

    always_comb begin
        state_d   = state_q;
        dev_d     = dev_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        req_d     = req_q;
        ok_d      = 1'b0;
        err_d     = 1'b0;
        code_d    = code_q;
        ack_tmr_d = ack_tmr_q;

        case (state_q)
            S_DEV: begin
                if (rx_vld) begin
                    if (rx_perr) begin
                        err_d   = 1'b1;
                        code_d  = ERR_PARITY;
                        state_d = S_DEV;
                    end else begin
                        dev_d   = rx_data;
                        state_d = S_ADDR;
                    end
                end
            end
            S_ADDR: begin
                if (rx_vld) begin
                    if (rx_perr) begin
                        err_d   = 1'b1;
                        code_d  = ERR_PARITY;
                        state_d = S_DEV;
                    end else begin
                        addr_d  = rx_data;
                        state_d = S_DATA;
                    end
                end
            end
            S_DATA: begin
                if (rx_vld) begin
                    if (rx_perr) begin
                        err_d   = 1'b1;
                        code_d  = ERR_PARITY;
                        state_d = S_DEV;
                    end else begin
                        wdata_d = rx_data;
                        state_d = S_TAIL;
                    end
                end
            end
            S_TAIL: begin
                if (rx_vld) begin
                    if (rx_perr) begin
                        err_d   = 1'b1;
                        code_d  = ERR_PARITY;
                        state_d = S_DEV;
                    end else if (rx_data != TAIL_BYTE) begin
                        // The bad terminator is dropped, not reinterpreted as the next DEV.
                        err_d   = 1'b1;
                        code_d  = ERR_TAIL;
                        state_d = S_DEV;
                    end else if (dev_q == DEV_ID) begin
                        req_d     = 1'b1;
                        ack_tmr_d = 16'd0;
                        state_d   = S_WR;
                    end else begin
                        state_d = S_DEV;
                    end
                end
            end
            S_WR: begin
                // Ack takes priority over a timeout expiring in the same cycle.
                if (cfg_wr_ack) begin
                    req_d   = 1'b0;
                    ok_d    = 1'b1;
                    state_d = S_DEV;
                end else if (ack_tmr_q + 16'd1 == ACK_TMO) begin
                    req_d   = 1'b0;
                    err_d   = 1'b1;
                    code_d  = ERR_ACK;
                    state_d = S_DEV;
                end else begin
                    ack_tmr_d = ack_tmr_q + 16'd1;
                end
            end
            default: begin
                req_d   = 1'b0;
                state_d = S_DEV;
            end
        endcase

`ifdef UART_CMD_TMO_EN
        idle_d = 24'd0;
        if ((state_q == S_ADDR) || (state_q == S_DATA) || (state_q == S_TAIL)) begin
            if (!rx_vld) begin
                if (idle_q + 24'd1 == BYTE_TMO) begin
                    err_d   = 1'b1;
                    code_d  = ERR_IDLE;
                    state_d = S_DEV;
                end else begin
                    idle_d = idle_q + 24'd1;
                end
            end
        end
`endif
    end

    always_ff @(posedge clk_sys or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_DEV;
            dev_q     <= 8'd0;
            addr_q    <= 8'd0;
            wdata_q   <= 8'd0;
            req_q     <= 1'b0;
            ok_q      <= 1'b0;
            err_q     <= 1'b0;
            code_q    <= 2'd0;
            ack_tmr_q <= 16'd0;
        end else begin
            state_q   <= state_d;
            dev_q     <= dev_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            req_q     <= req_d;
            ok_q      <= ok_d;
            err_q     <= err_d;
            code_q    <= code_d;
            ack_tmr_q <= ack_tmr_d;
        end
    end

`ifdef UART_CMD_TMO_EN
    always_ff @(posedge clk_sys or negedge rst_n) begin
        if (!rst_n) begin
            idle_q <= 24'd0;
        end else begin
            idle_q <= idle_d;
        end
    end
`endif

    assign cfg_wr_req = req_q;
    assign cfg_dev    = dev_q;
    assign cfg_addr   = addr_q;
    assign cfg_wdata  = wdata_q;
    assign busy       = (state_q == S_WR);
    assign frm_ok     = ok_q;
    assign frm_err    = err_q;
    assign err_code   = code_q;

endmodule

// File: tb/tb_uart_cmd_ctrl.sv
// Directed plus randomized frames for uart_cmd_ctrl, checked against a byte-queue frame model.
module tb_uart_cmd_ctrl;
    localparam logic [7:0] DEV_ID  = 8'h01;
    localparam logic [7:0] TAIL    = 8'hAA;
    localparam int         ACK_TMO = 1023;

    logic       clk_sys = 1'b0;
    logic       rst_n = 1'b0;
    logic       rx_vld = 1'b0;
    logic [7:0] rx_data = 8'd0;
    logic       rx_perr = 1'b0;
    logic       cfg_wr_ack = 1'b0;
    logic       cfg_wr_req, busy, frm_ok, frm_err;
    logic [7:0] cfg_dev, cfg_addr, cfg_wdata;
    logic [1:0] err_code;

    int checks = 0;
    int failures = 0;

    logic [7:0] mq[$];
    logic [1:0] last_code = 2'd0;

    uart_cmd_ctrl #(
        .DEV_ID(DEV_ID), .TAIL_BYTE(TAIL), .ACK_TMO(16'(ACK_TMO))
`ifdef UART_CMD_TMO_EN
        , .BYTE_TMO(24'd100)
`endif
    ) dut (
        .clk_sys(clk_sys), .rst_n(rst_n), .rx_vld(rx_vld), .rx_data(rx_data),
        .rx_perr(rx_perr), .cfg_wr_req(cfg_wr_req), .cfg_dev(cfg_dev),
        .cfg_addr(cfg_addr), .cfg_wdata(cfg_wdata), .cfg_wr_ack(cfg_wr_ack),
        .busy(busy), .frm_ok(frm_ok), .frm_err(frm_err), .err_code(err_code)
    );

    always #5 clk_sys = ~clk_sys;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_sys);
        #1;
    endtask

    // Holds req for d cycles (junk byte on the first), then acks.
    task automatic do_write(input int d);
        for (int i = 0; i < d; i++) begin
            if (i == 0) begin
                rx_vld  = 1'b1;
                rx_data = 8'($urandom);
                rx_perr = 1'($urandom_range(0, 1));
            end
            tick();
            rx_vld  = 1'b0;
            rx_perr = 1'b0;
            chk("wr_req_hold", cfg_wr_req, 1);
            chk("wr_busy", busy, 1);
            chk("wr_no_pulse", {frm_ok, frm_err}, 0);
        end
        cfg_wr_ack = 1'b1;
        tick();
        cfg_wr_ack = 1'b0;
        chk("ack_req_drop", cfg_wr_req, 0);
        chk("ack_frm_ok", frm_ok, 1);
        chk("ack_no_err", frm_err, 0);
        chk("ack_busy_low", busy, 0);
        tick();
        chk("frm_ok_width", frm_ok, 0);
    endtask

    // ack_d < 0 leaves the write phase to the caller.
    task automatic send_byte(input logic [7:0] b, input logic perr, input int ack_d);
        logic       exp_err;
        logic       exp_wr;
        logic [7:0] d0, a0, w0;
        exp_err = 1'b0;
        exp_wr  = 1'b0;
        d0 = 8'd0; a0 = 8'd0; w0 = 8'd0;
        if (perr) begin
            exp_err   = 1'b1;
            last_code = 2'd0;
            mq.delete();
        end else begin
            mq.push_back(b);
            if (mq.size() == 4) begin
                if (mq[3] != TAIL) begin
                    exp_err   = 1'b1;
                    last_code = 2'd1;
                end else if (mq[0] == DEV_ID) begin
                    exp_wr = 1'b1;
                    d0 = mq[0]; a0 = mq[1]; w0 = mq[2];
                end
                mq.delete();
            end
        end
        rx_vld  = 1'b1;
        rx_data = b;
        rx_perr = perr;
        tick();
        rx_vld  = 1'b0;
        rx_perr = 1'b0;
        chk("rx_err", frm_err, exp_err);
        chk("rx_code", err_code, last_code);
        chk("rx_req", cfg_wr_req, exp_wr);
        chk("rx_ok", frm_ok, 0);
        if (exp_wr) begin
            chk("wr_dev", cfg_dev, d0);
            chk("wr_addr", cfg_addr, a0);
            chk("wr_wdata", cfg_wdata, w0);
            chk("wr_busy_first", busy, 1);
            if (ack_d >= 0) do_write(ack_d);
        end
    endtask

    task automatic send_frame(input logic [7:0] b0, input logic [7:0] b1,
                              input logic [7:0] b2, input logic [7:0] b3, input int ack_d);
        send_byte(b0, 1'b0, ack_d);
        send_byte(b1, 1'b0, ack_d);
        send_byte(b2, 1'b0, ack_d);
        send_byte(b3, 1'b0, ack_d);
    endtask

    initial begin
        int n;
        int errs;
        logic [7:0] fb[4];
        int kind, perr_pos;

        // Reset state
        repeat (3) tick();
        chk("rst_req", cfg_wr_req, 0);
        chk("rst_busy", busy, 0);
        chk("rst_pulses", {frm_ok, frm_err}, 0);
        chk("rst_code", err_code, 0);
        chk("rst_regs", {cfg_dev, cfg_addr, cfg_wdata}, 0);
        rst_n = 1'b1;
        tick();

        // Stray ack outside a write
        cfg_wr_ack = 1'b1;
        tick();
        cfg_wr_ack = 1'b0;
        chk("stray_ack_ok", frm_ok, 0);
        chk("stray_ack_req", cfg_wr_req, 0);

        send_frame(8'h01, 8'h00, 8'h85, 8'hAA, 3);
        send_frame(8'h01, 8'h00, 8'h85, 8'h55, 1);
        send_frame(8'h01, 8'h10, 8'h22, 8'hAA, 1);
        send_byte(8'h01, 1'b0, 0);
        send_byte(8'h00, 1'b0, 0);
        send_byte(8'h85, 1'b1, 0);
        send_frame(8'h01, 8'h00, 8'h85, 8'hAA, 0);
        send_frame(8'h02, 8'h00, 8'h85, 8'hAA, 2);
        send_frame(8'h01, 8'h00, 8'h85, 8'hAA, 2);

        // Ack withheld: req must stay up for exactly ACK_TMO cycles
        send_frame(8'h01, 8'h33, 8'h44, 8'hAA, -1);
        n = 1;
        while (cfg_wr_req && n < 3000) begin
            tick();
            if (cfg_wr_req) n++;
        end
        last_code = 2'd3;
        chk("ack_tmo_len", n, ACK_TMO);
        chk("ack_tmo_err", frm_err, 1);
        chk("ack_tmo_code", err_code, 3);
        chk("ack_tmo_ok", frm_ok, 0);
        tick();
        chk("ack_tmo_err_width", frm_err, 0);

        // Ack on the expiry cycle wins
        send_frame(8'h01, 8'h55, 8'h66, 8'hAA, -1);
        repeat (ACK_TMO - 1) tick();
        chk("late_ack_req", cfg_wr_req, 1);
        cfg_wr_ack = 1'b1;
        tick();
        cfg_wr_ack = 1'b0;
        chk("late_ack_ok", frm_ok, 1);
        chk("late_ack_err", frm_err, 0);
        chk("late_ack_req_drop", cfg_wr_req, 0);
        tick();

        // Inter-byte idle behaviour
        send_byte(8'h01, 1'b0, 0);
        send_byte(8'h00, 1'b0, 0);
`ifdef UART_CMD_TMO_EN
        n = 0;
        for (int i = 1; i <= 120; i++) begin
            tick();
            if (frm_err && n == 0) n = i;
        end
        mq.delete();
        last_code = 2'd2;
        chk("idle_tmo_at", n, 100);
        chk("idle_tmo_code", err_code, 2);
        send_byte(8'h01, 1'b0, 0);
        repeat (99) tick();
        send_byte(8'h00, 1'b0, 0);
        send_byte(8'h85, 1'b0, 0);
        send_byte(8'hAA, 1'b0, 1);
`else
        errs = 0;
        for (int i = 0; i < 120; i++) begin
            tick();
            if (frm_err) errs++;
        end
        chk("idle_no_tmo", errs, 0);
        send_byte(8'h85, 1'b0, 0);
        send_byte(8'hAA, 1'b0, 1);
`endif

        // Reset during a write
        send_frame(8'h01, 8'h77, 8'h88, 8'hAA, -1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("rst_wr_req", cfg_wr_req, 0);
        chk("rst_wr_busy", busy, 0);
        chk("rst_wr_regs", {cfg_dev, cfg_addr, cfg_wdata}, 0);
        tick();
        rst_n = 1'b1;
        mq.delete();
        last_code = 2'd0;
        tick();
        chk("rst_wr_code", err_code, 0);
        send_frame(8'h01, 8'h99, 8'h5A, 8'hAA, 1);

        // Randomized frames
        for (int f = 0; f < 40; f++) begin
            kind = $urandom_range(0, 9);
            fb[0] = (kind == 8) ? 8'($urandom) : DEV_ID;
            fb[1] = 8'($urandom);
            fb[2] = 8'($urandom);
            fb[3] = TAIL;
            if (kind == 7) begin
                do fb[3] = 8'($urandom); while (fb[3] == TAIL);
            end
            perr_pos = (kind == 9) ? $urandom_range(0, 3) : 4;
            for (int i = 0; i < 4; i++) begin
                if (i == perr_pos) begin
                    send_byte(fb[i], 1'b1, 0);
                    break;
                end
                send_byte(fb[i], 1'b0, $urandom_range(0, 5));
                repeat ($urandom_range(0, 2)) tick();
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
